mem_port_arbiter: RTL

Shares the core's single main-memory port between the instruction-side miss path (I) and the data-side cache management path (D). It serialises one line-sized burst per grant and applies round-robin on contention. It raises per-side wait signals that feed the pipeline stall logic in the same way the cache-management stall does. It sits between the two cache controllers and the memory interface.

---
 rtl/mem_port_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Round-robin owner of the single memory port; moves one line-sized
//            burst per grant for the I-miss path or the D-cache path.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BURST  = 4,
  parameter int BW     = (BURST > 1) ? $clog2(BURST) : 1
) (
  input  logic              clk,
  input  logic              rst,
  // instruction-side miss path
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_wait,
  // data-side cache management path
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [BW-1:0]     d_beat,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_wait,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                c_BYTES     = DATA_W / 8;
  localparam int                c_LINE_BITS = $clog2(BURST * c_BYTES);
  localparam logic [ADDR_W-1:0] c_LINE_MASK = ~((ADDR_W'(1) << c_LINE_BITS) - ADDR_W'(1));
  localparam logic [BW-1:0]     c_LAST_BEAT = BW'(BURST - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_BUS_I = 2'd1;
  localparam logic [1:0] c_BUS_D = 2'd2;
  localparam logic [1:0] c_RESP  = 2'd3;

  logic [1:0]        r_state;
  logic [BW-1:0]     r_beat;
  logic [ADDR_W-1:0] r_base;
  logic              r_last_d;   // 1: D held the previous grant
  logic              r_gnt_d;    // side owning the current/just-finished burst

  logic              w_bus_i;
  logic              w_bus_d;
  logic              w_bus;
  logic              w_pick_d;
  logic              w_pick_i;
  logic              w_d_read;
  logic [ADDR_W-1:0] w_beat_off;

  // On a tie the side that did not own the last grant wins.
  assign w_pick_d = d_req & (~i_req | ~r_last_d);
  assign w_pick_i = i_req & ~w_pick_d;

  assign w_bus_i  = (r_state == c_BUS_I);
  assign w_bus_d  = (r_state == c_BUS_D);
  assign w_bus    = w_bus_i | w_bus_d;
  assign w_d_read = w_bus_d & ~d_we;

  assign w_beat_off = ADDR_W'(r_beat) * ADDR_W'(c_BYTES);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_beat   <= '0;
      r_base   <= '0;
      r_last_d <= 1'b0;
      r_gnt_d  <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_pick_d) begin
            r_state  <= c_BUS_D;
            r_base   <= d_addr & c_LINE_MASK;
            r_beat   <= '0;
            r_last_d <= 1'b1;
            r_gnt_d  <= 1'b1;
          end else if (w_pick_i) begin
            r_state  <= c_BUS_I;
            r_base   <= i_addr & c_LINE_MASK;
            r_beat   <= '0;
            r_last_d <= 1'b0;
            r_gnt_d  <= 1'b0;
          end
        end
        c_BUS_I, c_BUS_D: begin
          if (mem_ack) begin
            if (r_beat == c_LAST_BEAT) begin
              r_state <= c_RESP;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        c_RESP: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = w_bus;
  assign mem_we    = w_bus_d & d_we;
  assign mem_addr  = w_bus ? (r_base + w_beat_off) : '0;
  assign mem_wdata = (w_bus_d & d_we) ? d_wdata : '0;

  // Read beats flow straight through from the memory port.
  assign i_rvalid = w_bus_i & mem_ack;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rvalid = w_d_read & mem_ack;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  assign d_beat = w_bus_d ? r_beat : '0;

  assign i_done = (r_state == c_RESP) & ~r_gnt_d;
  assign d_done = (r_state == c_RESP) &  r_gnt_d;

  assign i_wait = i_req & ~i_done;
  assign d_wait = d_req & ~d_done;

endmodule
`default_nettype wire
